// File: rtl/bram_burst_reader.sv
// Burst reader: issues sequential reads to a one-cycle-latency BRAM and streams
// the returned words through a 4-entry FIFO, tagging the final word with m_last.
module bram_burst_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int BIT_WIDTH  = 32,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [BIT_WIDTH-1:0]  rdo,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BIT_WIDTH-1:0]  m_data,
    output logic                  m_last
);

    // Stream handshake: a word transfers on a clock edge where m_valid and
    // m_ready are both high; once m_valid rises, m_data/m_last hold until that
    // transfer, and m_valid never drops without one.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic                  pend;
    logic                  pend_last;
    logic [BIT_WIDTH-1:0]  fifo_data [4];
    logic [3:0]            fifo_last;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_count;
    logic [2:0]            outstanding;
    logic                  re_c;
    logic                  accept;
    logic                  done_next;
    logic                  fifo_pop;
    logic                  issue_last;

    // A read is outstanding for exactly the cycle after re, so a single flag
    // suffices as the count.
    assign outstanding = {2'b00, pend};
    assign issue_last  = (issued + LEN_WIDTH'(1)) == len_q;
    assign fifo_pop    = m_valid && m_ready;

    always_comb begin
        state_next = state;
        re_c       = 1'b0;
        accept     = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if ((issued < len_q) && ((fifo_count + outstanding) < 3'd4)) begin
                    re_c = 1'b1;
                    if (issue_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && m_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            issued     <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
        end else begin
            state     <= state_next;
            done      <= done_next;
            pend      <= re_c;
            pend_last <= re_c && issue_last;
            if (accept) begin
                base_q <= base_addr;
                len_q  <= burst_len;
                issued <= '0;
            end else if (re_c) begin
                issued <= issued + LEN_WIDTH'(1);
            end
            if (pend) begin
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({pend, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: m_data is gated by m_valid, which follows the count.
    always_ff @(posedge clk) begin
        if (pend) begin
            fifo_data[wr_ptr] <= rdo;
        end
    end

    assign busy    = (state != IDLE);
    assign re      = re_c;
    assign raddr   = base_q + ADDR_WIDTH'(issued);
    assign m_valid = (fifo_count != 3'd0);
    assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last  = m_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: BRAM model, queue-based burst model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bram_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [11:0] burst_len = '0;
  logic        busy;
  logic        done;
  logic        re;
  logic [11:0] raddr;
  logic [31:0] rdo = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;

  logic [31:0] mem [0:4095];

  int n_checks = 0;
  int n_fail = 0;

  // model state
  logic [31:0] exp_q[$];
  bit          exp_last_q[$];
  logic [11:0] exp_addr_q[$];
  bit          model_busy = 0;
  bit          exp_done = 0;
  bit          prev_stall = 0;
  int          inflight = 0;
  int          max_inflight = 0;
  int          words_seen = 0;
  int          done_seen = 0;

  bram_burst_reader #(.ADDR_WIDTH(12), .BIT_WIDTH(32), .LEN_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .busy(busy), .done(done), .re(re), .raddr(raddr), .rdo(rdo),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // BRAM with one-cycle registered read; output holds while re is low
  always @(posedge clk) begin
    if (re) rdo <= mem[raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // scoreboard / model: one compare process, sampled on the falling edge
  always @(negedge clk) begin
    bit nb;
    bit nd;
    logic [11:0] a;
    nb = model_busy;
    nd = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      exp_addr_q.delete();
      nb = 1'b0;
      inflight = 0;
      prev_stall = 1'b0;
    end else begin
      chk("busy", busy, model_busy);
      chk("done", done, exp_done);
      if (done) done_seen++;
      if (prev_stall) chk("valid_held", m_valid, 1);
      if (re) begin
        if (exp_addr_q.size() == 0) fail_now("re_unexpected");
        else chk("raddr", raddr, exp_addr_q.pop_front());
        chk("fifo_room", inflight < 4, 1);
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("valid_unexpected");
        end else begin
          chk("m_data", m_data, exp_q[0]);
          chk("m_last", m_last, exp_last_q[0]);
          if (m_ready) begin
            words_seen++;
            inflight--;
            void'(exp_q.pop_front());
            if (exp_last_q.pop_front()) begin
              nd = 1'b1;
              nb = 1'b0;
            end
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      if (start && !model_busy) begin
        if (burst_len == 12'd0) begin
          nd = 1'b1;
        end else begin
          nb = 1'b1;
          for (int i = 0; i < int'(burst_len); i++) begin
            a = base_addr + 12'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(mem[a]);
            exp_last_q.push_back(i == int'(burst_len) - 1);
          end
        end
      end
    end
    model_busy = nb;
    exp_done = nd;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!model_busy && exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) fail_now(name);
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", re, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
  endtask

  task automatic test_basic();
    start = 1'b1;
    base_addr = 12'h010;
    burst_len = 12'd4;
    m_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      start = 1'b0;
      chk("t_basic_re", re, k <= 4);
      if (k <= 4) chk("t_basic_raddr", raddr, 32'h10 + k - 1);
      chk("t_basic_valid", m_valid, k >= 3 && k <= 6);
      if (k >= 3 && k <= 6) chk("t_basic_data", m_data, 32'hA0 + k - 3);
      chk("t_basic_last", m_last, k == 6);
      chk("t_basic_done", done, k == 7);
      chk("t_basic_busy", busy, k <= 6);
    end
    wait_idle("t_basic_timeout");
  endtask

  task automatic test_wrap();
    logic [11:0] seen[$];
    logic [11:0] want [4];
    want[0] = 12'hFFE;
    want[1] = 12'hFFF;
    want[2] = 12'h000;
    want[3] = 12'h001;
    start = 1'b1;
    base_addr = 12'hFFE;
    burst_len = 12'd4;
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      if (re) seen.push_back(raddr);
    end
    chk("t_wrap_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t_wrap_raddr", seen[i], want[i]);
    wait_idle("t_wrap_timeout");
  endtask

  task automatic test_zero();
    start = 1'b1;
    base_addr = 12'h123;
    burst_len = 12'd0;
    step();
    start = 1'b0;
    chk("t_zero_done", done, 1);
    chk("t_zero_re", re, 0);
    chk("t_zero_valid", m_valid, 0);
    chk("t_zero_busy", busy, 0);
    step();
    chk("t_zero_done_once", done, 0);
    chk("t_zero_valid2", m_valid, 0);
    wait_idle("t_zero_timeout");
  endtask

  task automatic test_backpressure();
    int w0;
    int d0;
    w0 = words_seen;
    d0 = done_seen;
    max_inflight = 0;
    start = 1'b1;
    base_addr = 12'($urandom);
    burst_len = 12'd8;
    m_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      start = 1'b0;
      m_ready = !(k >= 4 && k <= 9);
      if (k >= 6 && k <= 9) chk("t_bp_re_stall", re, 0);
    end
    m_ready = 1'b1;
    chk("t_bp_words", words_seen - w0, 8);
    chk("t_bp_max_buffered", max_inflight, 4);
    chk("t_bp_done", done_seen - d0, 1);
    wait_idle("t_bp_timeout");
  endtask

  task automatic test_reset_mid();
    int w0;
    int d0;
    bit hit;
    w0 = words_seen;
    hit = 1'b0;
    start = 1'b1;
    base_addr = 12'($urandom);
    burst_len = 12'd8;
    m_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      start = 1'b0;
      if (words_seen - w0 >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) fail_now("t_rst_mid_timeout");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t_rst_mid_busy", busy, 0);
    chk("t_rst_mid_done", done, 0);
    chk("t_rst_mid_re", re, 0);
    chk("t_rst_mid_raddr", raddr, 0);
    chk("t_rst_mid_valid", m_valid, 0);
    chk("t_rst_mid_last", m_last, 0);
    chk("t_rst_mid_data", m_data, 0);
    d0 = done_seen;
    for (int i = 0; i < 6; i++) step();
    chk("t_rst_mid_no_done", done_seen - d0, 0);
    w0 = words_seen;
    start = 1'b1;
    base_addr = 12'($urandom);
    burst_len = 12'd2;
    step();
    start = 1'b0;
    wait_idle("t_rst_mid_next_timeout");
    chk("t_rst_mid_next_words", words_seen - w0, 2);
    chk("t_rst_mid_next_done", done_seen - d0, 1);
  endtask

  task automatic test_start_busy();
    int w0;
    bit got;
    w0 = words_seen;
    got = 1'b0;
    m_ready = 1'b1;
    start = 1'b1;
    base_addr = 12'h200;
    burst_len = 12'd6;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    base_addr = 12'h300;
    burst_len = 12'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      fail_now("t_busy_done_timeout");
    end else begin
      chk("t_busy_ignored_words", words_seen - w0, 6);
      start = 1'b1;
      base_addr = 12'h400;
      burst_len = 12'd3;
      step();
      start = 1'b0;
      chk("t_busy_accept_in_done", busy, 1);
    end
    wait_idle("t_busy_timeout");
    chk("t_busy_total_words", words_seen - w0, 9);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      base_addr = 12'($urandom);
      burst_len = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 16));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    m_ready = 1'b1;
    wait_idle("t_rand_drain_timeout");
    chk("t_rand_drained", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[12'h010] = 32'hA0;
    mem[12'h011] = 32'hA1;
    mem[12'h012] = 32'hA2;
    mem[12'h013] = 32'hA3;
    do_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
